// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM address-port arbiter: requester indices,
// FSM state encoding, mux select encodings and small arbitration helpers.
package ram_port_arbiter_pkg;

    localparam int NUM_REQ  = 4;
    localparam int REQ_DEC  = 0;
    localparam int REQ_FILE = 1;
    localparam int REQ_CNN  = 2;
    localparam int REQ_LYR  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Select triple driven into ST_Bit_MUX.
    typedef struct packed {
        logic layer;
        logic load;
        logic image;
    } sel_t;

    localparam sel_t SEL_DEC  = '{layer: 1'b0, load: 1'b1, image: 1'b0};
    localparam sel_t SEL_FILE = '{layer: 1'b0, load: 1'b1, image: 1'b1};
    localparam sel_t SEL_CNN  = '{layer: 1'b0, load: 1'b0, image: 1'b0};
    localparam sel_t SEL_LYR  = '{layer: 1'b1, load: 1'b0, image: 1'b0};

    // Mux selects that route the given requester's address to the RAM.
    function automatic sel_t sel_for(input logic [1:0] idx);
        case (idx)
            2'(REQ_DEC):  sel_for = SEL_DEC;
            2'(REQ_FILE): sel_for = SEL_FILE;
            2'(REQ_CNN):  sel_for = SEL_CNN;
            default:      sel_for = SEL_LYR;
        endcase
    endfunction

    // Round-robin pick: search ptr+1, ptr+2, ... (mod 4). Walking from the
    // farthest candidate to the nearest lets the nearest one overwrite.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] cand;
        rr_pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) rr_pick = cand;
        end
    endfunction

endpackage

// File: rtl/ram_port_arbiter_st_bit_mux.sv
// Existing 4:1 RAM address mux. Layer has priority, then Load (with Image
// choosing FILE over DEC); with all selects low the CNN address passes.
module ST_Bit_MUX #(
    parameter int ADDR_W = 16
) (
    input  logic              Load,
    input  logic              Image,
    input  logic              Layer,
    input  logic [ADDR_W-1:0] AddressInDecompressed,
    input  logic [ADDR_W-1:0] AddressInFile,
    input  logic [ADDR_W-1:0] AddressInCNN,
    input  logic [ADDR_W-1:0] AddressLayerInput,
    output logic [ADDR_W-1:0] AddressToRAM
);

    // Select the address source from the three mux controls.
    always_comb begin
        AddressToRAM = AddressInCNN;
        if (Layer)
            AddressToRAM = AddressLayerInput;
        else if (Load)
            AddressToRAM = Image ? AddressInFile : AddressInDecompressed;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the single RAM address port among DEC, FILE,
// CNN and LYR. Each grant is a burst of Len words, followed by a one-cycle
// turnaround gap before the next arbitration.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int BURST_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [NUM_REQ*BURST_W-1:0] Len,
    input  logic [NUM_REQ-1:0]         We,
    input  logic [ADDR_W-1:0]          AddressInDecompressed,
    input  logic [ADDR_W-1:0]          AddressInFile,
    input  logic [ADDR_W-1:0]          AddressInCNN,
    input  logic [ADDR_W-1:0]          AddressLayerInput,
    output logic [NUM_REQ-1:0]         Grant,
    output logic [NUM_REQ-1:0]         Done,
    output logic                       Load,
    output logic                       Image,
    output logic                       Layer,
    output logic [ADDR_W-1:0]          AddressToRAM,
    output logic                       RamEn,
    output logic                       RamWe,
    output logic                       Busy
);

    state_t               r_state,   w_state_nxt;
    logic [1:0]           r_ptr,     w_ptr_nxt;
    logic [1:0]           r_win,     w_win_nxt;
    logic [BURST_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [NUM_REQ-1:0]   r_grant,   w_grant_nxt;
    logic [NUM_REQ-1:0]   r_done,    w_done_nxt;
    sel_t                 r_sel,     w_sel_nxt;
    logic                 r_ram_en,  w_ram_en_nxt;

    logic [1:0]           w_pick;
    logic [BURST_W-1:0]   w_pick_len;

    assign w_pick     = rr_pick(Req, r_ptr);
    assign w_pick_len = Len[int'(w_pick)*BURST_W +: BURST_W];

    // Next-state and next-output logic for the IDLE/BURST/GAP sequencer.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a
        // variable unassigned; an incomplete path here would infer a latch.
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_win_nxt    = r_win;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_sel_nxt    = r_sel;
        w_ram_en_nxt = r_ram_en;

        case (r_state)
            IDLE: begin
                if (|Req) begin
                    w_win_nxt = w_pick;
                    w_ptr_nxt = w_pick;
                    w_cnt_nxt = w_pick_len;
                    if (w_pick_len == '0) begin
                        // Empty burst: report completion without touching RAM.
                        w_done_nxt  = NUM_REQ'(1) << w_pick;
                        w_state_nxt = GAP;
                    end else begin
                        w_grant_nxt  = NUM_REQ'(1) << w_pick;
                        w_sel_nxt    = sel_for(w_pick);
                        w_ram_en_nxt = 1'b1;
                        w_state_nxt  = BURST;
                    end
                end
            end

            BURST: begin
                if (!Req[r_win]) begin
                    // Requester withdrew: abort silently, no Done.
                    w_grant_nxt  = '0;
                    w_ram_en_nxt = 1'b0;
                    w_state_nxt  = GAP;
                end else if (r_cnt == BURST_W'(1)) begin
                    w_done_nxt   = NUM_REQ'(1) << r_win;
                    w_grant_nxt  = '0;
                    w_ram_en_nxt = 1'b0;
                    w_state_nxt  = GAP;
                end else begin
                    w_cnt_nxt = r_cnt - BURST_W'(1);
                end
            end

            GAP: begin
                // Turnaround cycle; selects keep their last value.
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt  = IDLE;
                w_grant_nxt  = '0;
                w_ram_en_nxt = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset drops any burst in flight.
    // NOTE: reset is asynchronous, so every output register clears the
    // instant rst_n falls rather than waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= 2'(REQ_LYR);
            r_win    <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_sel    <= SEL_CNN;
            r_ram_en <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from
            // the same pre-edge values, independent of statement order.
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_win    <= w_win_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_sel    <= w_sel_nxt;
            r_ram_en <= w_ram_en_nxt;
        end
    end

    assign Grant = r_grant;
    assign Done  = r_done;
    assign Load  = r_sel.load;
    assign Image = r_sel.image;
    assign Layer = r_sel.layer;
    assign RamEn = r_ram_en;
    assign RamWe = r_ram_en & |(We & r_grant);
    assign Busy  = (r_state != IDLE);

    ST_Bit_MUX #(
        .ADDR_W (ADDR_W)
    ) u_st_bit_mux (
        .Load                  (r_sel.load),
        .Image                 (r_sel.image),
        .Layer                 (r_sel.layer),
        .AddressInDecompressed (AddressInDecompressed),
        .AddressInFile         (AddressInFile),
        .AddressInCNN          (AddressInCNN),
        .AddressLayerInput     (AddressLayerInput),
        .AddressToRAM          (AddressToRAM)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: each stimulus step pushes the
// cycle-stamped RAM-port activity it expects; a negedge monitor pops and
// compares whenever the DUT shows any activity.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  Req;
    logic [31:0] Len;
    logic [3:0]  We;
    logic [15:0] AddressInDecompressed;
    logic [15:0] AddressInFile;
    logic [15:0] AddressInCNN;
    logic [15:0] AddressLayerInput;
    logic [3:0]  Grant;
    logic [3:0]  Done;
    logic        Load, Image, Layer;
    logic [15:0] AddressToRAM;
    logic        RamEn, RamWe, Busy;

    ram_port_arbiter #(.ADDR_W(16), .BURST_W(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .Req                   (Req),
        .Len                   (Len),
        .We                    (We),
        .AddressInDecompressed (AddressInDecompressed),
        .AddressInFile         (AddressInFile),
        .AddressInCNN          (AddressInCNN),
        .AddressLayerInput     (AddressLayerInput),
        .Grant                 (Grant),
        .Done                  (Done),
        .Load                  (Load),
        .Image                 (Image),
        .Layer                 (Layer),
        .AddressToRAM          (AddressToRAM),
        .RamEn                 (RamEn),
        .RamWe                 (RamWe),
        .Busy                  (Busy)
    );

    // Expected selects as {Layer, Load, Image}.
    localparam logic [2:0] S_DEC  = 3'b010;
    localparam logic [2:0] S_FILE = 3'b011;
    localparam logic [2:0] S_CNN  = 3'b000;
    localparam logic [2:0] S_LYR  = 3'b100;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        ram_en;
        logic        ram_we;
        logic [2:0]  sel;
        logic [15:0] addr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_ev;
    ev_t exp_ev;
    int  n_vec  = 0;
    int  n_miss = 0;
    int  cyc    = 0;
    int  k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic set_len(input int idx, input logic [7:0] v);
        Len[idx*8 +: 8] = v;
    endtask

    task automatic push_burst(input int base, input int idx, input int len, input logic we,
                              input logic [2:0] sel, input logic [15:0] addr, input bit with_done);
        ev_t e;
        for (int i = 0; i < len; i++) begin
            e.cyc    = int'(base + i);
            e.grant  = 4'b0001 << idx;
            e.done   = 4'b0000;
            e.ram_en = 1'b1;
            e.ram_we = we;
            e.sel    = sel;
            e.addr   = addr;
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.cyc    = int'(base + len);
            e.grant  = 4'b0000;
            e.done   = 4'b0001 << idx;
            e.ram_en = 1'b0;
            e.ram_we = 1'b0;
            e.sel    = 3'b000;
            e.addr   = 16'h0000;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: any visible port activity is one scoreboard comparison.
    always @(negedge clk) begin
        if (RamEn || RamWe || (|Grant) || (|Done)) begin
            obs_ev.cyc    = cyc;
            obs_ev.grant  = Grant;
            obs_ev.done   = Done;
            obs_ev.ram_en = RamEn;
            obs_ev.ram_we = RamWe;
            obs_ev.sel    = RamEn ? {Layer, Load, Image} : 3'b000;
            obs_ev.addr   = RamEn ? AddressToRAM : 16'h0000;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_event: got cyc=%0d grant=%b done=%b en=%b we=%b sel=%b addr=%h, expected no activity",
                         obs_ev.cyc, obs_ev.grant, obs_ev.done, obs_ev.ram_en, obs_ev.ram_we, obs_ev.sel, obs_ev.addr);
            end else begin
                exp_ev = exp_q.pop_front();
                if (obs_ev !== exp_ev) begin
                    n_miss++;
                    $display("FAIL port_event: got cyc=%0d grant=%b done=%b en=%b we=%b sel=%b addr=%h, expected cyc=%0d grant=%b done=%b en=%b we=%b sel=%b addr=%h",
                             obs_ev.cyc, obs_ev.grant, obs_ev.done, obs_ev.ram_en, obs_ev.ram_we, obs_ev.sel, obs_ev.addr,
                             exp_ev.cyc, exp_ev.grant, exp_ev.done, exp_ev.ram_en, exp_ev.ram_we, exp_ev.sel, exp_ev.addr);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        Req   = 4'b0000;
        Len   = 32'h0;
        We    = 4'b0000;
        AddressInDecompressed = 16'h0009;
        AddressInFile         = 16'h2222;
        AddressInCNN          = 16'h3333;
        AddressLayerInput     = 16'h4444;

        // Reset state.
        @(negedge clk); #1;
        check("rst_grant", 32'(Grant), 32'h0);
        check("rst_done",  32'(Done),  32'h0);
        check("rst_ramen", 32'(RamEn), 32'h0);
        check("rst_sel",   32'({Layer, Load, Image}), 32'h0);
        check("rst_busy",  32'(Busy),  32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // DEC, Len=3.
        k = cyc;
        Req = 4'b0001;
        set_len(0, 8'd3);
        push_burst(k + 1, 0, 3, 1'b0, S_DEC, 16'h0009, 1'b1);
        at_cyc(k + 4);
        Req = 4'b0000;
        @(negedge clk); #1;
        check("dec_gap_busy", 32'(Busy), 32'h1);
        at_cyc(k + 5);
        @(negedge clk); #1;
        check("dec_idle_busy", 32'(Busy), 32'h0);

        // Restart so round-robin begins at DEC, then all four request Len=2.
        @(negedge clk); #2;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        AddressInDecompressed = 16'h1111;
        Len = {8'd2, 8'd2, 8'd2, 8'd2};
        k = cyc;
        Req = 4'b1111;
        push_burst(k + 1,  0, 2, 1'b0, S_DEC,  16'h1111, 1'b1);
        push_burst(k + 5,  1, 2, 1'b0, S_FILE, 16'h2222, 1'b1);
        push_burst(k + 9,  2, 2, 1'b0, S_CNN,  16'h3333, 1'b1);
        push_burst(k + 13, 3, 2, 1'b0, S_LYR,  16'h4444, 1'b1);
        push_burst(k + 17, 0, 2, 1'b0, S_DEC,  16'h1111, 1'b1);
        at_cyc(k + 19);
        Req = 4'b0000;
        at_cyc(k + 21);

        // FILE Len=10 aborted after 4 accesses; CNN waits and follows.
        k = cyc;
        set_len(1, 8'd10);
        set_len(2, 8'd2);
        Req = 4'b0110;
        push_burst(k + 1, 1, 4, 1'b0, S_FILE, 16'h2222, 1'b0);
        push_burst(k + 7, 2, 2, 1'b0, S_CNN,  16'h3333, 1'b1);
        at_cyc(k + 4);
        Req = 4'b0100;
        at_cyc(k + 5);
        @(negedge clk); #1;
        check("abort_busy",  32'(Busy),  32'h1);
        check("abort_ramen", 32'(RamEn), 32'h0);
        check("abort_done",  32'(Done),  32'h0);
        at_cyc(k + 9);
        Req = 4'b0000;
        at_cyc(k + 11);

        // LYR with Len=0: Done only.
        k = cyc;
        set_len(3, 8'd0);
        Req = 4'b1000;
        push_burst(k + 1, 3, 0, 1'b0, S_LYR, 16'h4444, 1'b1);
        at_cyc(k + 1);
        Req = 4'b0000;
        @(negedge clk); #1;
        check("len0_busy", 32'(Busy), 32'h1);
        at_cyc(k + 2);
        @(negedge clk); #1;
        check("len0_idle_busy", 32'(Busy), 32'h0);
        at_cyc(k + 4);

        // CNN Len=8, asynchronous reset after 3 accesses.
        k = cyc;
        set_len(2, 8'd8);
        Req = 4'b0100;
        push_burst(k + 1, 2, 3, 1'b0, S_CNN, 16'h3333, 1'b0);
        at_cyc(k + 3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(Grant), 32'h0);
        check("arst_done",  32'(Done),  32'h0);
        check("arst_ramen", 32'(RamEn), 32'h0);
        check("arst_sel",   32'({Layer, Load, Image}), 32'h0);
        check("arst_busy",  32'(Busy),  32'h0);
        check("arst_addr",  32'(AddressToRAM), 32'h3333);
        Req = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        k = cyc;
        Req = 4'b0100;
        push_burst(k + 1, 2, 8, 1'b0, S_CNN, 16'h3333, 1'b1);
        at_cyc(k + 9);
        Req = 4'b0000;
        at_cyc(k + 11);

        // DEC write burst; FILE's We is up but FILE is never granted.
        k = cyc;
        We = 4'b0011;
        set_len(0, 8'd2);
        Req = 4'b0001;
        push_burst(k + 1, 0, 2, 1'b1, S_DEC, 16'h1111, 1'b1);
        @(negedge clk); #1;
        check("we_idle_ramwe", 32'(RamWe), 32'h0);
        at_cyc(k + 3);
        Req = 4'b0000;
        at_cyc(k + 4);
        @(negedge clk); #1;
        check("we_after_ramwe", 32'(RamWe), 32'h0);
        at_cyc(k + 5);

        // DEC read while every other requester asserts We.
        k = cyc;
        We = 4'b1110;
        set_len(0, 8'd1);
        Req = 4'b0001;
        push_burst(k + 1, 0, 1, 1'b0, S_DEC, 16'h1111, 1'b1);
        at_cyc(k + 2);
        Req = 4'b0000;
        at_cyc(k + 4);

        tick(3);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
